// File: rtl/roi_scan_io.sv
// Serial scan harness: CHAINS lanes shift stimulus into din and shift captured ROI results out.
// Define SCAN_CRC_EN to add the crc/crc_last CRC-8 ports. Serial out is named "so" because "do" is a keyword.
module roi_scan_io #(
    parameter int DIN_N  = 256,
    parameter int DOUT_N = 256,
    parameter int CHAINS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              stb,
    input  logic [CHAINS-1:0] di,
    output logic [CHAINS-1:0] so,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout,
    output logic              full,
    output logic              short_err,
    output logic [CNT_W-1:0]  frame_cnt
`ifdef SCAN_CRC_EN
    ,
    output logic [7:0]        crc,
    output logic [7:0]        crc_last
`endif
);

    localparam int L  = DIN_N / CHAINS;
    localparam int M  = DOUT_N / CHAINS;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DIN_N-1:0]  din_shr, din_shr_sh;
    logic [DOUT_N-1:0] dout_shr, dout_shr_sh;

    // Per-lane shifted images; the output chain is fed from the MSB of the matching input lane.
    for (genvar k = 0; k < CHAINS; k++) begin : g_lane
        if (L == 1) begin : g_in1
            assign din_shr_sh[k*L] = di[k];
        end else begin : g_inn
            assign din_shr_sh[k*L +: L] = {din_shr[k*L +: L-1], di[k]};
        end
        if (M == 1) begin : g_out1
            assign dout_shr_sh[k*M] = din_shr[k*L+L-1];
        end else begin : g_outn
            assign dout_shr_sh[k*M +: M] = {dout_shr[k*M +: M-1], din_shr[k*L+L-1]};
        end
        assign so[k] = dout_shr[k*M+M-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_shr   <= '0;
            dout_shr  <= '0;
            din       <= '0;
            frame_cnt <= '0;
            short_err <= 1'b0;
        end else begin
            if (sen) begin
                din_shr <= din_shr_sh;
            end
            if (stb) begin
                din       <= din_shr;
                dout_shr  <= dout;
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (!full) begin
                    short_err <= 1'b1;
                end
            end else if (sen) begin
                dout_shr <= dout_shr_sh;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // A strobe restarts the frame, counting the bit shifted in that same cycle.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        state_nxt   = FILL;
        if (stb) begin
            bit_cnt_nxt = sen ? CW'(1) : '0;
        end else if (sen && (bit_cnt != CW'(L))) begin
            bit_cnt_nxt = bit_cnt + CW'(1);
        end
        if (bit_cnt_nxt == '0) begin
            state_nxt = EMPTY;
        end else if (bit_cnt_nxt == CW'(L)) begin
            state_nxt = FULL;
        end
    end

    assign full = (state == FULL);

`ifdef SCAN_CRC_EN
    function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc      <= '0;
            crc_last <= '0;
        end else if (stb) begin
            crc_last <= crc;
            crc      <= sen ? crc8_bit(8'h00, di[0]) : 8'h00;
        end else if (sen) begin
            crc <= crc8_bit(crc, di[0]);
        end
    end
`endif

endmodule
